// File: rtl/pc_sequencer_pkg.sv
// Shared widths, reset/start values and state encoding for the fetch-side PC sequencer.
package pc_sequencer_pkg;

  localparam int unsigned PC_W     = 11;
  localparam int unsigned LUT_AW   = 5;
  localparam int unsigned START_PC = 0;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned STACK_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_e;

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address stack used by pc_sequencer when RET_STACK_EN is defined.
// Push when full discards the oldest entry; pop when empty is a no-op.
module ret_stack #(
  parameter int unsigned W     = 11,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [CW-1:0] cnt;
  logic          full;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] top_idx;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign wr_idx  = AW'(cnt);
  assign top_idx = AW'(cnt - CW'(1));
  assign dout    = empty ? '0 : mem[top_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (pop) begin
      if (!empty) cnt <= cnt - CW'(1);
    end else if (push) begin
      if (full) begin
        // slide everything toward the bottom so the oldest entry falls off
        for (int unsigned i = 0; i + 1 < DEPTH; i++) mem[i] <= mem[i+1];
        mem[DEPTH-1] <= din;
      end else begin
        mem[wr_idx] <= din;
        cnt         <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-side program counter sequencer: IDLE/RUN/HALT, LUT branches, instruction count.
// Optional 4-deep call/return stack enabled by defining RET_STACK_EN.
module pc_sequencer #(
  parameter int unsigned PC_W     = pc_sequencer_pkg::PC_W,
  parameter int unsigned LUT_AW   = pc_sequencer_pkg::LUT_AW,
  parameter int unsigned START_PC = pc_sequencer_pkg::START_PC,
  parameter int unsigned CNT_W    = pc_sequencer_pkg::CNT_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Stall,
  input  logic              Halt,
  input  logic              BranchEn,
  input  logic              BranchTaken,
  input  logic [LUT_AW-1:0] LutIdx,
  input  logic [PC_W-1:0]   LutTarget,
`ifdef RET_STACK_EN
  input  logic              Call,
  input  logic              Ret,
  output logic              StackErr,
`endif
  output logic [LUT_AW-1:0] LutAddr,
  output logic [PC_W-1:0]   PC,
  output logic              Busy,
  output logic              Done,
  output logic [CNT_W-1:0]  InstCnt
);

  import pc_sequencer_pkg::*;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d, pc_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

  assign pc_inc  = pc_q + PC_W'(1);
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  assign LutAddr = LutIdx;
  assign PC      = pc_q;
  assign InstCnt = cnt_q;
  assign Busy    = (state_q == RUN);
  assign Done    = (state_q == HALT);

`ifdef RET_STACK_EN
  logic            stk_push, stk_pop, stk_clr, stk_empty, err_set, err_q;
  logic [PC_W-1:0] stk_top;

  ret_stack #(
    .W     (PC_W),
    .DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk   (Clk),
    .rst   (Reset),
    .clr   (stk_clr),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (pc_inc),
    .dout  (stk_top),
    .empty (stk_empty)
  );

  assign StackErr = err_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)        err_q <= 1'b0;
    else if (stk_clr) err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
`ifdef RET_STACK_EN
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    stk_clr  = 1'b0;
    err_set  = 1'b0;
`endif
    case (state_q)
      IDLE, HALT: begin
        if (Start) begin
          state_d = RUN;
          pc_d    = PC_W'(START_PC);
          cnt_d   = '0;
`ifdef RET_STACK_EN
          stk_clr = 1'b1;
`endif
        end
      end
      RUN: begin
        // every unstalled RUN cycle retires exactly one instruction, halt included
        if (!Stall) begin
          cnt_d = cnt_inc;
          if (Halt) begin
            state_d = HALT;
`ifdef RET_STACK_EN
          end else if (Ret) begin
            if (stk_empty) begin
              pc_d    = pc_inc;
              err_set = 1'b1;
            end else begin
              pc_d    = stk_top;
              stk_pop = 1'b1;
            end
          end else if (Call) begin
            pc_d     = LutTarget;
            stk_push = 1'b1;
`endif
          end else if (BranchEn && BranchTaken) begin
            pc_d = LutTarget;
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
